// File: rtl/branch_target_buffer_pkg.sv
// btb_pkg: shared definitions for the branch target buffer.
//   BTB_ENTRIES       default table depth
//   CTR_*             2-bit direction counter encodings
//   CTR_ALLOC         counter value written on allocation (weak taken)
//   CTR_RESET         counter value after reset (weak not-taken)
//   TAG_MAXW          width of the tag field in the entry struct
//   btb_entry_t       one table entry (valid, tag, target, ctr)
package btb_pkg;

  localparam int BTB_ENTRIES = 64;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_ALLOC = CTR_WT;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // The struct cannot follow the ENTRIES parameter, so the tag field is
  // sized for the smallest legal table (4 entries). Shorter tags are stored
  // right-aligned with zero upper bits.
  localparam int TAG_MAXW = 28;

  typedef struct packed {
    logic                valid;
    logic [TAG_MAXW-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: fetch-side lookup and EX-side training/redirect
// signals of the branch target buffer.
//   slave  modport: the BTB (consumes PCF and EX inputs, drives predictions
//                   and the redirect)
//   master modport: the pipeline side (drives PCF and EX inputs)
interface branch_target_buffer_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [31:0] PCE;
  logic        BrInstE;
  logic        StallE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredE;
  logic [31:0] RedirectPCE;

  modport slave (
    input  PCF, PCE, BrInstE, StallE, BranchE, BranchTargetE,
           PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredE, RedirectPCE
  );

  modport master (
    output PCF, PCE, BrInstE, StallE, BranchE, BranchTargetE,
           PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredE, RedirectPCE
  );
endinterface

// File: rtl/branch_target_buffer_sat_ctr.sv
// btb_sat_ctr: next value of a 2-bit saturating direction counter.
//   ctr   current counter
//   taken resolved direction (1 = step up, 0 = step down)
//   nxt   next counter, saturating at CTR_ST / CTR_SNT
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   btb          branch_target_buffer_if.slave
//                  PCF -> PredTakenF/PredTargetF (combinational lookup)
//                  EX inputs -> MispredE/RedirectPCE (combinational) and
//                  table training on the following clock edge
//   BrCountO     (BTB_STATS_EN only) saturating count of updates
//   MispCountO   (BTB_STATS_EN only) saturating count of mispredicts
// Optional feature macro: BTB_STATS_EN.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_target_buffer_if.slave btb
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]           BrCountO,
  output logic [31:0]           MispCountO
`endif
);

  btb_entry_t tbl [ENTRIES];

  function automatic logic [TAG_MAXW-1:0] tag_of(input logic [31:0] pc);
    tag_of = TAG_MAXW'(pc >> (IDXW + 2));
  endfunction

  // Fetch-side lookup
  logic [IDXW-1:0] idx_f;
  btb_entry_t      ent_f;
  logic            hit_f;
  logic            unused_pcf;

  assign idx_f       = btb.PCF[IDXW+1:2];
  assign ent_f       = tbl[idx_f];
  assign hit_f       = ent_f.valid && (ent_f.tag == tag_of(btb.PCF));
  assign btb.PredTakenF  = hit_f && ent_f.ctr[1];
  assign btb.PredTargetF = btb.PredTakenF ? ent_f.target : 32'h0;
  assign unused_pcf  = ^btb.PCF[1:0];

  // EX-side resolution
  logic            upd;
  logic [IDXW-1:0] idx_e;
  btb_entry_t      ent_e;
  logic            hit_e;
  logic [1:0]      ctr_nxt;

  assign upd   = btb.BrInstE && !btb.StallE;
  assign idx_e = btb.PCE[IDXW+1:2];
  assign ent_e = tbl[idx_e];
  assign hit_e = ent_e.valid && (ent_e.tag == tag_of(btb.PCE));

  assign btb.MispredE = upd && ((btb.BranchE ^ btb.PredTakenE) ||
                        (btb.BranchE && btb.PredTakenE &&
                         (btb.PredTargetE != btb.BranchTargetE)));
  assign btb.RedirectPCE = btb.BranchE ? btb.BranchTargetE : (btb.PCE + 32'd4);

  btb_sat_ctr u_ctr (
    .ctr   (ent_e.ctr),
    .taken (btb.BranchE),
    .nxt   (ctr_nxt)
  );

  // Table write: lands on the edge after upd, so same-cycle lookups see old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_RESET};
      end
    end else if (upd) begin
      if (hit_e) begin
        tbl[idx_e].ctr <= ctr_nxt;
        if (btb.BranchE) tbl[idx_e].target <= btb.BranchTargetE;
      end else if (btb.BranchE) begin
        // Allocation evicts whatever aliases at this index
        tbl[idx_e] <= '{valid: 1'b1, tag: tag_of(btb.PCE),
                        target: btb.BranchTargetE, ctr: CTR_ALLOC};
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BrCountO   <= 32'h0;
      MispCountO <= 32'h0;
    end else begin
      if (upd && (BrCountO != 32'hFFFF_FFFF)) BrCountO <= BrCountO + 32'd1;
      if (btb.MispredE && (MispCountO != 32'hFFFF_FFFF))
        MispCountO <= MispCountO + 32'd1;
    end
  end
`endif

endmodule
